// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared states, address map and slave select codes for the APB bridge
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
    localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
    localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
    localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational address to one-hot slave select decoder
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    output logic [2:0]    psel,
    output logic          valid
);

    logic [31:0] a32;

    assign a32 = 32'(addr);

    always_comb begin
        psel  = PSEL_NONE;
        valid = 1'b0;
        if (a32 >= REGION0_BASE && a32 <= REGION0_LIMIT) begin
            psel  = PSEL_S0;
            valid = 1'b1;
        end else if (a32 >= REGION1_BASE && a32 <= REGION1_LIMIT) begin
            psel  = PSEL_S1;
            valid = 1'b1;
        end else if (a32 >= REGION2_BASE && a32 <= REGION2_LIMIT) begin
            psel  = PSEL_S2;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - single-outstanding command to APB master with decode and timeout
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [2:0]    psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [AW-1:0] pwdata,
    input  logic [AW-1:0] prdata,
    input  logic          pready
);

    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic [2:0]    psel_d;
    logic          penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
    logic [AW-1:0] paddr_d, pwdata_d, rsp_rdata_d;
    logic [2:0]    dec_psel;
    logic          dec_valid;

    apb_addr_decode #(.AW(AW)) u_decode (
        .addr  (cmd_addr),
        .psel  (dec_psel),
        .valid (dec_valid)
    );

    // Gated by hreset so no command can be offered while the block is held in reset.
    assign cmd_ready = (state == IDLE) && !hreset;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            psel      <= PSEL_NONE;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        psel_d      = psel;
        penable_d   = penable;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    if (dec_valid) begin
                        psel_d    = dec_psel;
                        penable_d = 1'b0;
                        state_d   = SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite ? '0 : prdata;
                    psel_d      = PSEL_NONE;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = PSEL_NONE;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - directed scoreboard bench for apb_master_fsm
module tb_apb_master_fsm;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 hclk = ~hclk;

    apb_master_fsm #(.TIMEOUT(16), .AW(32)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // The slave raises pready once it has seen 'waits' ACCESS cycles with pready low.
    task automatic do_cmd(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input logic [31:0] rdata_v,
                          input logic [2:0] exp_psel, input logic exp_err,
                          input int exp_lat, input int exp_acc);
        rsp_t exp_r;
        rsp_t got_exp;
        int   cyc;
        int   acc;
        logic done;
        logic stable;
        @(posedge hclk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        prdata    = rdata_v;
        pready    = (waits == 0);
        @(negedge hclk);
        check_bit({name, ".cmd_ready_idle"}, cmd_ready, 1'b1);
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        exp_r.err   = exp_err;
        exp_r.rdata = (exp_err || wr) ? 32'h0 : rdata_v;
        exp_q.push_back(exp_r);
        cyc    = 0;
        acc    = 0;
        done   = 1'b0;
        stable = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge hclk);
            cyc++;
            if (cyc == 1) begin
                check({name, ".psel_setup"}, 32'(psel), 32'(exp_psel));
                check_bit({name, ".penable_setup"}, penable, 1'b0);
            end
            if (cyc == 2 && exp_psel != 3'b000)
                check_bit({name, ".penable_access"}, penable, 1'b1);
            if (psel != 3'b000) begin
                if (psel !== exp_psel || paddr !== addr || pwdata !== wdata || pwrite !== wr)
                    stable = 1'b0;
            end
            if (penable) begin
                acc++;
                pready = (acc > waits);
            end
            if (rsp_valid) begin
                done    = 1'b1;
                got_exp = exp_q.pop_front();
                check({name, ".rsp_rdata"}, rsp_rdata, got_exp.rdata);
                check_bit({name, ".rsp_err"}, rsp_err, got_exp.err);
                check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
                check({name, ".access_cycles"}, 32'(acc), 32'(exp_acc));
                check({name, ".psel_resp"}, 32'(psel), 32'h0);
                check_bit({name, ".penable_resp"}, penable, 1'b0);
                check_bit({name, ".cmd_ready_resp"}, cmd_ready, 1'b0);
            end
        end
        check_bit({name, ".rsp_seen"}, done, 1'b1);
        check_bit({name, ".apb_stable"}, stable, 1'b1);
        pready = 1'b1;
    endtask

    initial begin
        logic saw_rsp;
        hreset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst.psel", 32'(psel), 32'h0);
        check_bit("rst.penable", penable, 1'b0);
        check_bit("rst.pwrite", pwrite, 1'b0);
        check("rst.paddr", paddr, 32'h0);
        check("rst.pwdata", pwdata, 32'h0);
        check_bit("rst.rsp_valid", rsp_valid, 1'b0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check_bit("rst.rsp_err", rsp_err, 1'b0);
        check_bit("rst.cmd_ready", cmd_ready, 1'b0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check_bit("rst.cmd_ready_rise", cmd_ready, 1'b1);

        do_cmd("wr_s0",     1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0,   32'h0,         3'b001, 1'b0, 3,  1);
        do_cmd("rd_s1",     1'b0, 32'h8400_0004, 32'h0,         0,   32'h0000_00A5, 3'b010, 1'b0, 3,  1);
        do_cmd("rd_s2_w3",  1'b0, 32'h8800_0000, 32'h1111_2222, 3,   32'h1234_5678, 3'b100, 1'b0, 6,  4);
        do_cmd("rd_bad",    1'b0, 32'h9000_0000, 32'h0,         0,   32'hFFFF_FFFF, 3'b000, 1'b1, 1,  0);
        do_cmd("rd_tmo",    1'b0, 32'h8000_0020, 32'h0,         100, 32'hCAFE_F00D, 3'b001, 1'b1, 18, 16);
        do_cmd("rd_s0_top", 1'b0, 32'h83FF_FFFC, 32'h0,         1,   32'h0BAD_CAFE, 3'b001, 1'b0, 4,  2);
        do_cmd("rd_s2_top", 1'b0, 32'h8BFF_FFFF, 32'h0,         0,   32'h7777_0001, 3'b100, 1'b0, 3,  1);
        do_cmd("rd_above",  1'b0, 32'h8C00_0000, 32'h0,         0,   32'h0,         3'b000, 1'b1, 1,  0);
        do_cmd("rd_below",  1'b1, 32'h7FFF_FFFF, 32'h1,         0,   32'h0,         3'b000, 1'b1, 1,  0);
        do_cmd("wr_s1_w2",  1'b1, 32'h8400_0000, 32'hA5A5_5A5A, 2,   32'h5555_AAAA, 3'b010, 1'b0, 5,  3);

        // Abort an in-flight read with reset; no response may escape.
        @(posedge hclk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h8000_0100;
        pready    = 1'b0;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        check_bit("mid_rst.in_access", penable, 1'b1);
        hreset = 1'b1;
        @(negedge hclk);
        check("mid_rst.psel", 32'(psel), 32'h0);
        check_bit("mid_rst.penable", penable, 1'b0);
        check("mid_rst.paddr", paddr, 32'h0);
        check_bit("mid_rst.rsp_valid", rsp_valid, 1'b0);
        check_bit("mid_rst.cmd_ready", cmd_ready, 1'b0);
        @(posedge hclk); #1;
        hreset  = 1'b0;
        pready  = 1'b1;
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check_bit("mid_rst.no_rsp", saw_rsp, 1'b0);

        do_cmd("post_rst",  1'b0, 32'h8400_0100, 32'h0,         0,   32'h0102_0304, 3'b010, 1'b0, 3,  1);

        check("scoreboard.empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
